// File: rtl/tpu_array_ctrl.sv
// Job sequencer for a DIM x DIM tpumac systolic array: C load/clear, A/B streaming, C drain.
// Outputs are decoded combinationally from state, cnt, load_c_q and stall.
module tpu_array_ctrl #(
  parameter  int DIM   = 8,
  localparam int CNT_W = $clog2(3*DIM),
  localparam int IDX_W = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_c,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             mac_en,
  output logic             mac_wren,
  output logic             ab_rd_en,
  output logic [IDX_W-1:0] ab_rd_idx,
  output logic             c_rd_en,
  output logic             c_zero,
  output logic [IDX_W-1:0] c_idx,
  output logic             cout_valid
);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, FINISH} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               load_c_q;
  logic               run;

  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(3*DIM - 3);
  localparam logic [CNT_W-1:0] ROWS      = CNT_W'(DIM);

  assign run = ~stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      load_c_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && start) load_c_q <= load_c;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    mac_en     = 1'b0;
    mac_wren   = 1'b0;
    ab_rd_en   = 1'b0;
    ab_rd_idx  = '0;
    c_rd_en    = 1'b0;
    c_zero     = 1'b0;
    c_idx      = '0;
    cout_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        mac_en   = run;
        mac_wren = run;
        c_rd_en  = load_c_q & run;
        c_zero   = ~load_c_q;
        c_idx    = cnt[IDX_W-1:0];
        if (run) begin
          if (cnt == ROW_LAST) begin
            state_n = COMPUTE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      COMPUTE: begin
        busy   = 1'b1;
        mac_en = run;
        // Past the last vector the skew buffers are left to flush zeros in.
        if (cnt < ROWS) begin
          ab_rd_en  = run;
          ab_rd_idx = cnt[IDX_W-1:0];
        end
        if (run) begin
          if (cnt == COMP_LAST) begin
            state_n = DRAIN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        mac_en     = run;
        mac_wren   = run;
        c_zero     = 1'b1;
        cout_valid = run;
        c_idx      = cnt[IDX_W-1:0];
        if (run) begin
          if (cnt == ROW_LAST) begin
            state_n = FINISH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_array_ctrl.sv
// Bench for tpu_array_ctrl at DIM=4: per-cycle scoreboard of all outputs plus a 4x4 tpumac
// array model driven by the sequencer to check preload/compute/drain end to end.
module tb_tpu_array_ctrl;
  localparam int DIM = 4;
  localparam int IW  = $clog2(DIM);

  typedef struct packed {
    logic          busy, done, mac_en, mac_wren, ab_rd_en;
    logic [IW-1:0] ab_rd_idx;
    logic          c_rd_en, c_zero;
    logic [IW-1:0] c_idx;
    logic          cout_valid;
  } ov_t;

  logic clk = 0, rst_n, start, load_c, stall;
  logic busy, done, mac_en, mac_wren, ab_rd_en, c_rd_en, c_zero, cout_valid;
  logic [IW-1:0] ab_rd_idx, c_idx;
  ov_t obs, exp_v;
  ov_t sb[$];
  int  dn[$];
  int  vectors = 0, miscompares = 0;

  tpu_array_ctrl #(.DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_c(load_c), .stall(stall),
    .busy(busy), .done(done), .mac_en(mac_en), .mac_wren(mac_wren),
    .ab_rd_en(ab_rd_en), .ab_rd_idx(ab_rd_idx), .c_rd_en(c_rd_en), .c_zero(c_zero),
    .c_idx(c_idx), .cout_valid(cout_valid)
  );

  assign obs = {busy, done, mac_en, mac_wren, ab_rd_en, ab_rd_idx, c_rd_en, c_zero, c_idx, cout_valid};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected outputs for cycles 1..n after an accepted start; stalled cycles s0..s1.
  function automatic void push_job(input bit lc, input int n, input int s0, input int s1);
    int ph = 1;
    int cnt = 0;
    for (int c = 1; c <= n; c++) begin
      bit  go = !(c >= s0 && c <= s1);
      ov_t e = '0;
      case (ph)
        1: begin
          e.busy = 1; e.mac_en = go; e.mac_wren = go; e.c_rd_en = lc & go;
          e.c_zero = !lc; e.c_idx = IW'(cnt);
          if (go) begin if (cnt == DIM-1) begin ph = 2; cnt = 0; end else cnt++; end
        end
        2: begin
          e.busy = 1; e.mac_en = go;
          if (cnt < DIM) begin e.ab_rd_en = go; e.ab_rd_idx = IW'(cnt); end
          if (go) begin if (cnt == 3*DIM-3) begin ph = 3; cnt = 0; end else cnt++; end
        end
        3: begin
          e.busy = 1; e.mac_en = go; e.mac_wren = go; e.c_zero = 1; e.cout_valid = go;
          e.c_idx = IW'(cnt);
          if (go) begin if (cnt == DIM-1) begin ph = 4; cnt = 0; end else cnt++; end
        end
        4: begin e.busy = 1; e.done = 1; ph = 0; end
        default: ;
      endcase
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst_n = 0; start = 1; load_c = 1; stall = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin rst_n = 1; start = 0; load_c = 0; stall = 0; end
      sb.push_back('0);
      @(negedge clk);
      vectors++;
      exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL reset cyc %0d: got %h want %h", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clear();
    sb.delete(); dn.delete();
    load_c = 0;
    sb.push_back('0);
    push_job(0, 20, -1, -1);
    for (int k = 0; k <= 20; k++) begin
      start = (k == 0);
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL clear cyc %0d: no expected entry", k); end
      else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL clear cyc %0d: got %h want %h", k, obs, exp_v);
        end
      end
      if (obs.done) dn.push_back(k);
      @(posedge clk); #1;
    end
    vectors++;
    if (dn.size() != 1 || dn[0] != 19) begin
      miscompares++; $display("FAIL clear_done: got %0d pulses first at %0d want 1 at 19",
                              dn.size(), dn.size() ? dn[0] : -1);
    end
  endtask

  task automatic test_preload();
    int a_m [DIM][DIM], b_m [DIM][DIM];
    int a_r [DIM][DIM], b_r [DIM][DIM], c_r [DIM][DIM];
    int na [DIM][DIM], nb [DIM][DIM];
    int drained [DIM][DIM];
    int rd_hist [3*DIM];
    int a_in [DIM], b_in [DIM];
    int t = 0, dk = 0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0; b_m[i][j] = (i == j) ? 2 : 0;
        a_r[i][j] = 0; b_r[i][j] = 0; c_r[i][j] = 0; drained[i][j] = -1;
      end
    sb.delete();
    load_c = 1;
    sb.push_back('0);
    push_job(1, 20, -1, -1);
    for (int k = 0; k <= 20; k++) begin
      start = (k == 0);
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL preload cyc %0d: no expected entry", k); end
      else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL preload cyc %0d: got %h want %h", k, obs, exp_v);
        end
      end
      // tpumac array: WrEn shifts C along each row, otherwise C += A*B with A right / B down.
      if (mac_en === 1'b1 && mac_wren === 1'b1) begin
        if (cout_valid === 1'b1 && dk < DIM) begin
          for (int i = 0; i < DIM; i++) drained[i][DIM-1-dk] = c_r[i][DIM-1];
          dk++;
        end
        for (int i = 0; i < DIM; i++) begin
          for (int j = DIM-1; j > 0; j--) c_r[i][j] = c_r[i][j-1];
          c_r[i][0] = (c_zero === 1'b1) ? 0 : 5;
        end
      end else if (mac_en === 1'b1 && t < 3*DIM) begin
        rd_hist[t] = (ab_rd_en === 1'b1) ? int'(ab_rd_idx) : -1;
        for (int l = 0; l < DIM; l++) begin
          a_in[l] = 0; b_in[l] = 0;
          if (t - l >= 0 && rd_hist[t-l] >= 0) begin
            a_in[l] = a_m[l][rd_hist[t-l]];
            b_in[l] = b_m[rd_hist[t-l]][l];
          end
        end
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) begin
            na[i][j] = (j == 0) ? a_in[i] : a_r[i][j-1];
            nb[i][j] = (i == 0) ? b_in[j] : b_r[i-1][j];
            c_r[i][j] += na[i][j] * nb[i][j];
          end
        a_r = na; b_r = nb;
        t++;
      end
      @(posedge clk); #1;
    end
    load_c = 0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        vectors++;
        if (drained[i][j] != ((i == j) ? 7 : 5)) begin
          miscompares++; $display("FAIL preload_result C[%0d][%0d]: got %0d want %0d",
                                  i, j, drained[i][j], (i == j) ? 7 : 5);
        end
      end
  endtask

  task automatic test_stall();
    sb.delete(); dn.delete();
    sb.push_back('0);
    push_job(0, 23, 6, 8);
    for (int k = 0; k <= 23; k++) begin
      start = (k == 0);
      stall = (k >= 6 && k <= 8);
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL stall cyc %0d: no expected entry", k); end
      else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL stall cyc %0d: got %h want %h", k, obs, exp_v);
        end
      end
      if (obs.done) dn.push_back(k);
      @(posedge clk); #1;
    end
    stall = 0;
    vectors++;
    if (dn.size() != 1 || dn[0] != 22) begin
      miscompares++; $display("FAIL stall_done: got %0d pulses first at %0d want 1 at 22",
                              dn.size(), dn.size() ? dn[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    sb.delete(); dn.delete();
    sb.push_back('0);
    push_job(0, 20, -1, -1);
    push_job(0, 20, -1, -1);
    for (int k = 0; k <= 40; k++) begin
      start = (k < 40);
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL b2b cyc %0d: no expected entry", k); end
      else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL b2b cyc %0d: got %h want %h", k, obs, exp_v);
        end
      end
      if (obs.done) dn.push_back(k);
      @(posedge clk); #1;
    end
    vectors++;
    if (dn.size() != 2 || dn[0] != 19 || dn[1] != 39) begin
      miscompares++; $display("FAIL b2b_done: got %0d pulses want 2 at 19,39", dn.size());
    end
  endtask

  task automatic test_reset_mid();
    sb.delete(); dn.delete();
    sb.push_back('0);
    push_job(0, 10, -1, -1);
    sb.push_back('0);
    sb.push_back('0);
    push_job(0, 20, -1, -1);
    for (int k = 0; k <= 32; k++) begin
      start = (k == 0 || k == 12);
      rst_n = (k != 10);
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL rst_mid cyc %0d: no expected entry", k); end
      else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL rst_mid cyc %0d: got %h want %h", k, obs, exp_v);
        end
      end
      if (obs.done) dn.push_back(k);
      @(posedge clk); #1;
    end
    rst_n = 1;
    vectors++;
    if (dn.size() != 1 || dn[0] != 31) begin
      miscompares++; $display("FAIL rst_mid_done: got %0d pulses first at %0d want 1 at 31",
                              dn.size(), dn.size() ? dn[0] : -1);
    end
  endtask

  task automatic test_done_stall();
    sb.delete(); dn.delete();
    sb.push_back('0);
    push_job(0, 21, 19, 19);
    for (int k = 0; k <= 21; k++) begin
      start = (k == 0 || k == 19);
      stall = (k == 19);
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL done_stall cyc %0d: no expected entry", k); end
      else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL done_stall cyc %0d: got %h want %h", k, obs, exp_v);
        end
      end
      if (obs.done) dn.push_back(k);
      @(posedge clk); #1;
    end
    start = 0; stall = 0;
    vectors++;
    if (dn.size() != 1 || dn[0] != 19) begin
      miscompares++; $display("FAIL done_stall_pulse: got %0d pulses want 1 at 19", dn.size());
    end
  endtask

  initial begin
    rst_n = 0; start = 0; load_c = 0; stall = 0;
    @(posedge clk); #1;
    test_reset();
    test_clear();
    test_preload();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_done_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
